// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus an
// iterative DSLLV shifter, with valid/ready handshakes on both sides.
module ex_alu_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = 6,
    parameter int SHIFT_STEP  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            ALU_control_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  illegal_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_DSLLV = 4'b1000;

    localparam logic [SHAMT_WIDTH:0] STEP = (SHAMT_WIDTH+1)'(SHIFT_STEP);

    state_t                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_WIDTH:0]    rem_q, rem_d;

    logic                    is_add, is_sub, is_and;
    logic                    is_or, is_slt, is_sll;
    logic [DATA_WIDTH-1:0]   op_res;
    logic                    op_ill;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [SHAMT_WIDTH:0]    step_amt;
    logic [SHAMT_WIDTH:0]    rem_left;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    accept;
    logic                    drain;

    assign is_add = (ALU_control_i == OP_ADD);
    assign is_sub = (ALU_control_i == OP_SUB);
    assign is_and = (ALU_control_i == OP_AND);
    assign is_or  = (ALU_control_i == OP_OR);
    assign is_slt = (ALU_control_i == OP_SLT);
    assign is_sll = (ALU_control_i == OP_DSLLV);

    assign shamt = a_i[SHAMT_WIDTH-1:0];

    assign in_ready_o = (state_q == IDLE) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign drain      = out_valid_q && out_ready_i;

    // Single-cycle datapath; DSLLV here only covers the zero-shift case.
    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        unique case (1'b1)
            is_add:  op_res = a_i + b_i;
            is_sub:  op_res = a_i - b_i;
            is_and:  op_res = a_i & b_i;
            is_or:   op_res = a_i | b_i;
            is_slt:  op_res = {{(DATA_WIDTH-1){1'b0}},
                               ($signed(a_i) < $signed(b_i))};
            is_sll:  op_res = b_i;
            default: op_ill = 1'b1;
        endcase
    end

    assign step_amt = (rem_q < STEP) ? rem_q : STEP;
    assign rem_left = rem_q - step_amt;
    assign shifted  = shreg_q << step_amt;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        if (flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            rem_d       = '0;
        end else begin
            if (drain) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_sll && shamt != '0) begin
                            shreg_d = b_i;
                            rem_d   = {1'b0, shamt};
                            state_d = SHIFT;
                        end else begin
                            result_d    = op_res;
                            zero_d      = (op_res == '0);
                            illegal_d   = op_ill;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg_d = shifted;
                    rem_d   = rem_left;
                    if (rem_left == '0) begin
                        result_d    = shifted;
                        zero_d      = (shifted == '0);
                        illegal_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            shreg_q     <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: ops, DSLLV latency,
// backpressure, illegal code, flush and mid-shift reset.
module tb_ex_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        illegal;

    int tests;
    int fails;

    ex_alu_unit #(
        .DATA_WIDTH (64),
        .SHAMT_WIDTH(6),
        .SHIFT_STEP (8)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .ALU_control_i(ctrl),
        .a_i          (a),
        .b_i          (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .zero_o       (zero),
        .illegal_o    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [63:0] x,
                         input logic [63:0] y);
        in_valid = 1'b1;
        ctrl     = c;
        a        = x;
        b        = y;
    endtask

    // Issue a DSLLV of b=1 and expect the result lat edges after accept.
    task automatic run_shift(input string tag, input logic [63:0] x,
                             input logic [63:0] exp, input int lat);
        int n;
        drive(4'b1000, x, 64'd1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, result, exp);
        step();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = 4'b0010;
        a         = '0;
        b         = '0;

        step();
        step();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd1);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step();
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_res", result, 64'd0);
        chk("add_zero", {63'd0, zero}, 64'd1);
        chk("add_ill", {63'd0, illegal}, 64'd0);
        drive(4'b0110, 64'd5, 64'd7);
        step();
        chk("sub_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_zero", {63'd0, zero}, 64'd0);
        drive(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        step();
        chk("slt_res", result, 64'd1);
        drive(4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("slt_neg_res", result, 64'd0);
        drive(4'b0000, 64'hF0, 64'h3C);
        step();
        chk("and_res", result, 64'h30);
        drive(4'b0001, 64'hF0, 64'h3C);
        step();
        chk("or_res", result, 64'hFC);
        chk("or_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        run_shift("sll0", 64'd0, 64'd1, 0);
        run_shift("sll8", 64'd8, 64'h100, 1);
        run_shift("sll9", 64'd9, 64'h200, 2);
        run_shift("sll63", 64'd63, 64'h8000_0000_0000_0000, 8);
        run_shift("sll41", 64'h41, 64'd2, 1);

        out_ready = 1'b0;
        drive(4'b0010, 64'd3, 64'd4);
        step();
        in_valid = 1'b0;
        chk("bp_res", result, 64'd7);
        step();
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_res", result, 64'd7);
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        drive(4'b0110, 64'd10, 64'd1);
        #1;
        chk("bp_ready_up", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_new_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_new_res", result, 64'd9);
        step();

        drive(4'b1111, 64'd3, 64'd4);
        step();
        in_valid = 1'b0;
        chk("ill_valid", {63'd0, out_valid}, 64'd1);
        chk("ill_res", result, 64'd0);
        chk("ill_zero", {63'd0, zero}, 64'd1);
        chk("ill_flag", {63'd0, illegal}, 64'd1);
        step();

        drive(4'b1000, 64'd40, 64'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("fl_quiet", {63'd0, out_valid}, 64'd0);
            step();
        end
        drive(4'b0010, 64'd2, 64'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_drop", {63'd0, out_valid}, 64'd0);
        step();
        in_valid = 1'b0;
        chk("fl_add_valid", {63'd0, out_valid}, 64'd1);
        chk("fl_add_res", result, 64'd4);
        chk("fl_add_ill", {63'd0, illegal}, 64'd0);
        step();

        drive(4'b1000, 64'd63, 64'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_zero", {63'd0, zero}, 64'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 12; i++) begin
            chk("arst_stale", {63'd0, out_valid}, 64'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
